prog_counter: RTL and testbench

PROG_COUNTER -- requirements
Module: prog_counter

---
 rtl/prog_counter.sv | 123 ++++++++++++
 tb/tb_prog_counter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_counter.sv
// Programmable up/down counter with prescaler, four counting modes and a
// shared-bus style output stage.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   en         count enable (gates prescaler and count advance)
//   load       synchronous load request, honoured only while oe=0
//   load_val   value loaded into the counter
//   dir        1 = count up, 0 = count down
//   mode       00 free-run, 01 modulo, 10 one-shot, 11 hold
//   limit      terminal value for modulo / one-shot up counting
//   prescale   one count step per prescale+1 enabled cycles
//   oe         1 = block drives the shared bus
//   count_out  count while oe=0, zero while oe=1
//   bus_out    count, always
//   bus_oe     every bit equals oe
//   tc         registered terminal-count pulse
//   done       one-shot complete flag
module prog_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic [PRE_W-1:0] prescale,
  input  logic             oe,
  output logic [WIDTH-1:0] count_out,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] bus_oe,
  output logic             tc,
  output logic             done
);

  typedef enum logic [0:0] {StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [PRE_W-1:0] pre_q;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] step;
  logic             load_ok;
  logic             active;
  logic             tick;
  logic             at_term;

  // A load while the block owns the bus is dropped entirely.
  assign load_ok = load & ~oe;

  // Prescaler only runs while counting is possible: not in hold mode, not finished.
  assign active  = en & (mode != 2'b11) & (state_q == StRun);
  assign tick    = active & (pre_q == prescale);

  always_comb begin
    term = '0;
    if (dir) begin
      term = (mode == 2'b00) ? '1 : limit;
    end
  end

  assign at_term = (count_q == term);
  assign step    = dir ? count_q + WIDTH'(1) : count_q - WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      pre_q   <= '0;
      state_q <= StRun;
      tc      <= 1'b0;
      done    <= 1'b0;
    end else if (load_ok) begin
      // Load wins over a coincident tick.
      count_q <= load_val;
      pre_q   <= '0;
      state_q <= StRun;
      tc      <= 1'b0;
      done    <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (active) begin
        pre_q <= tick ? '0 : pre_q + PRE_W'(1);
      end
      if (tick) begin
        case (mode)
          2'b00: begin
            count_q <= step;
            tc      <= at_term;
          end
          2'b01: begin
            // Up: anything at or above limit (e.g. a loaded value) wraps to 0.
            if (dir) begin
              count_q <= (count_q >= limit) ? '0 : step;
            end else begin
              count_q <= (count_q == '0) ? limit : step;
            end
            tc <= at_term;
          end
          2'b10: begin
            if (at_term) begin
              state_q <= StDone;
              tc      <= 1'b1;
              done    <= 1'b1;
            end else begin
              count_q <= step;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus_out   = count_q;
  assign count_out = oe ? '0 : count_q;
  assign bus_oe    = {WIDTH{oe}};

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter (WIDTH=8, PRE_W=4). A behavioural model
// predicts count/tc/done for every clock; predictions are queued when inputs
// are driven and popped for comparison after the edge.
module tb_prog_counter;

  logic       clk = 1'b0;
  logic       rst, en, load, dir, oe;
  logic [7:0] load_val, limit;
  logic [1:0] mode;
  logic [3:0] prescale;
  logic [7:0] count_out, bus_out, bus_oe;
  logic       tc, done;

  prog_counter #(.WIDTH(8), .PRE_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .dir(dir),
    .mode(mode), .limit(limit), .prescale(prescale), .oe(oe),
    .count_out(count_out), .bus_out(bus_out), .bus_oe(bus_oe), .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] c;
    logic       t;
    logic       d;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int tc_seen;

  // Model state
  logic [7:0] m_cnt;
  logic [3:0] m_pre;
  logic       m_tc, m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 8'd0; m_pre = 4'd0; m_tc = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step();
    logic       tk;
    logic [7:0] tv;
    if (load && !oe) begin
      m_cnt = load_val; m_pre = 4'd0; m_done = 1'b0; m_tc = 1'b0;
      return;
    end
    m_tc = 1'b0;
    tk   = 1'b0;
    if (en && mode != 2'd3 && !m_done) begin
      if (m_pre == prescale) begin
        tk = 1'b1; m_pre = 4'd0;
      end else begin
        m_pre = m_pre + 4'd1;
      end
    end
    if (tk) begin
      tv = !dir ? 8'h00 : (mode == 2'd0 ? 8'hFF : limit);
      case (mode)
        2'd0: begin
          m_tc  = (m_cnt == tv);
          m_cnt = dir ? m_cnt + 8'd1 : m_cnt - 8'd1;
        end
        2'd1: begin
          m_tc = (m_cnt == tv);
          if (dir) m_cnt = (m_cnt >= limit) ? 8'd0 : m_cnt + 8'd1;
          else     m_cnt = (m_cnt == 8'd0) ? limit : m_cnt - 8'd1;
        end
        2'd2: begin
          if (m_cnt == tv) begin
            m_tc = 1'b1; m_done = 1'b1;
          end else begin
            m_cnt = dir ? m_cnt + 8'd1 : m_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  endtask

  // One clock: predict, push, clock, pop and compare. Entered and left at negedge.
  task automatic cyc(input string tag);
    exp_t e;
    model_step();
    sb.push_back('{c: m_cnt, t: m_tc, d: m_done});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".count"}, 32'(bus_out), 32'(e.c));
    chk({tag, ".tc"}, 32'(tc), 32'(e.t));
    chk({tag, ".done"}, 32'(done), 32'(e.d));
    chk({tag, ".count_out"}, 32'(count_out), oe ? 32'd0 : 32'(e.c));
    chk({tag, ".bus_oe"}, 32'(bus_oe), oe ? 32'hFF : 32'h00);
    if (tc) tc_seen++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; dir = 1'b1; oe = 1'b0;
    load_val = 8'h00; limit = 8'h00; mode = 2'd0; prescale = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.count", 32'(bus_out), 32'd0);
    chk("rst.tc", 32'(tc), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    rst = 1'b0;

    // Free-run up wrap 0xFF -> 0x00 with one tc
    en = 1'b1; tc_seen = 0;
    for (int i = 0; i < 258; i++) cyc("wrap");
    chk("wrap.tc_cnt", 32'(tc_seen), 32'd1);
    chk("wrap.end", 32'(bus_out), 32'd2);

    // Modulo 10, prescale 2: one tc per 30 cycles
    mode = 2'd1; limit = 8'd9; prescale = 4'd2;
    load = 1'b1; load_val = 8'd0; cyc("mod.load"); load = 1'b0;
    tc_seen = 0;
    for (int i = 0; i < 60; i++) cyc("mod");
    chk("mod.tc_cnt", 32'(tc_seen), 32'd2);
    chk("mod.end", 32'(bus_out), 32'd0);

    // One-shot down from 5
    mode = 2'd2; dir = 1'b0; prescale = 4'd0;
    load = 1'b1; load_val = 8'd5; cyc("os.load"); load = 1'b0;
    tc_seen = 0;
    for (int i = 0; i < 10; i++) cyc("os");
    chk("os.done", 32'(done), 32'd1);
    chk("os.count", 32'(bus_out), 32'd0);
    chk("os.tc_cnt", 32'(tc_seen), 32'd1);
    mode = 2'd0; dir = 1'b1;
    for (int i = 0; i < 5; i++) cyc("os.hold");
    chk("os.hold_done", 32'(done), 32'd1);
    chk("os.hold_cnt", 32'(bus_out), 32'd0);
    mode = 2'd2; dir = 1'b0;
    load = 1'b1; load_val = 8'd3; cyc("os.reload"); load = 1'b0;
    chk("os.reload_done", 32'(done), 32'd0);
    chk("os.reload_cnt", 32'(bus_out), 32'd3);
    for (int i = 0; i < 6; i++) cyc("os2");

    // Load ignored while oe=1
    en = 1'b0; oe = 1'b1; load = 1'b1; load_val = 8'hAA;
    cyc("oe_load");
    chk("oe.count_out", 32'(count_out), 32'd0);
    chk("oe.bus_oe", 32'(bus_oe), 32'hFF);
    chk("oe.bus_out", 32'(bus_out), 32'(m_cnt));
    load = 1'b0; oe = 1'b0;

    // Load beats a coincident terminal tick
    mode = 2'd0; dir = 1'b1; prescale = 4'd0; en = 1'b1;
    load = 1'b1; load_val = 8'hFF; cyc("ld.ff");
    load_val = 8'h40; cyc("ld.40");
    chk("ld.count", 32'(bus_out), 32'h40);
    chk("ld.tc", 32'(tc), 32'd0);
    load = 1'b0;
    cyc("ld.after");
    chk("ld.next", 32'(bus_out), 32'h41);

    // Asynchronous reset mid one-shot run
    mode = 2'd2; dir = 1'b1; limit = 8'h30; prescale = 4'd1;
    load = 1'b1; load_val = 8'h10; cyc("ar.load"); load = 1'b0;
    for (int i = 0; i < 6; i++) cyc("ar.run");
    #2 rst = 1'b1;
    #1;
    chk("ar.bus_out", 32'(bus_out), 32'd0);
    chk("ar.count_out", 32'(count_out), 32'd0);
    chk("ar.done", 32'(done), 32'd0);
    chk("ar.tc", 32'(tc), 32'd0);
    model_reset();
    #1 rst = 1'b0;
    cyc("ar.r1");
    chk("ar.first", 32'(bus_out), 32'd0);
    cyc("ar.r2");
    chk("ar.second", 32'(bus_out), 32'd1);

    // Random mix of all controls
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 7) != 0);
      load     = ($urandom_range(0, 15) == 0);
      oe       = ($urandom_range(0, 3) == 0);
      load_val = 8'($urandom_range(0, 255));
      if (i % 25 == 0) begin
        mode     = 2'($urandom_range(0, 3));
        dir      = 1'($urandom_range(0, 1));
        limit    = 8'($urandom_range(0, 15));
        prescale = 4'($urandom_range(0, 3));
      end
      cyc("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
